// File: rtl/mem_bus_if.sv
// Memory-side bus of the unified 128x32 memory.
// The memory latches writes on the falling clock edge.
interface mem_bus_if;
    logic [31:0] mem_dir;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_read_data;

    modport master (
        output mem_dir,
        output mem_write_data,
        output mem_memwrite,
        output mem_memread,
        input  mem_read_data
    );

    modport slave (
        input  mem_dir,
        input  mem_write_data,
        input  mem_memwrite,
        input  mem_memread,
        output mem_read_data
    );
endinterface

// File: rtl/mem_bus_initiator.sv
// Arbitrates fetch and data ports onto the memory bus.
// Address legality is checked before any memory strobe is raised.
module mem_bus_initiator #(
    parameter logic [31:0] TEXT_BASE  = 32'h00400000,
    parameter int unsigned TEXT_WORDS = 6,
    parameter logic [31:0] DATA_BASE  = 32'h10000000,
    parameter int unsigned DATA_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    mem_bus_if.master   bus
);

    localparam logic [31:0] TEXT_END = TEXT_BASE + 32'(4 * TEXT_WORDS);
    localparam logic [31:0] DATA_END = DATA_BASE + 32'(4 * DATA_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_d;
    logic        port_d;
    logic        we_q;
    logic [31:0] dir_q;
    logic [31:0] wdata_q;
    logic        memread_q;
    logic        memwrite_q;

    logic        sel_d;
    logic        accept;
    logic        a_we;
    logic [31:0] a_addr;
    logic        in_text;
    logic        in_data;
    logic        legal;
    logic        rsp_en;
    logic        rsp_d;
    logic        rsp_err;
    logic [31:0] rsp_data;

    // Data wins only when alone or when fetch had the previous grant.
    assign sel_d   = d_req && (!i_req || !last_d);
    assign i_ready = (state == IDLE) && i_req && !sel_d;
    assign d_ready = (state == IDLE) && sel_d;
    assign accept  = i_ready || d_ready;

    assign a_we    = sel_d && d_we;
    assign a_addr  = sel_d ? d_addr : i_addr;
    assign in_text = (a_addr >= TEXT_BASE) && (a_addr < TEXT_END);
    assign in_data = (a_addr >= DATA_BASE) && (a_addr < DATA_END);
    assign legal   = (a_addr[1:0] == 2'b00)
                   && (in_data || (in_text && !a_we));

    assign rsp_en   = (accept && !legal) || (state == BUS);
    assign rsp_d    = (state == BUS) ? port_d : sel_d;
    assign rsp_err  = (state != BUS);
    assign rsp_data = ((state == BUS) && !we_q) ? bus.mem_read_data : 32'h0;

    assign bus.mem_dir        = dir_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_memread    = memread_q;
    assign bus.mem_memwrite   = memwrite_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = legal ? BUS : RESP;
                end
            end
            BUS:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d     <= 1'b1;
            port_d     <= 1'b0;
            we_q       <= 1'b0;
            dir_q      <= 32'h0;
            wdata_q    <= 32'h0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            i_valid    <= 1'b0;
            i_rdata    <= 32'h0;
            i_err      <= 1'b0;
            d_valid    <= 1'b0;
            d_rdata    <= 32'h0;
            d_err      <= 1'b0;
        end else begin
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            if (accept) begin
                last_d <= sel_d;
                port_d <= sel_d;
                we_q   <= a_we;
            end
            if (accept && legal) begin
                dir_q      <= a_addr;
                memread_q  <= !a_we;
                memwrite_q <= a_we;
                if (a_we) begin
                    wdata_q <= d_wdata;
                end
            end
            if (rsp_en) begin
                if (rsp_d) begin
                    d_valid <= 1'b1;
                    d_rdata <= rsp_data;
                    d_err   <= rsp_err;
                end else begin
                    i_valid <= 1'b1;
                    i_rdata <= rsp_data;
                    i_err   <= rsp_err;
                end
            end
        end
    end

endmodule
